// File: rtl/qreg_uart_tx.sv
// qreg_uart_tx: byte FIFO plus UART transmitter. It takes each byte the CPU
// writes to its output register and sends it on txd as an asynchronous frame:
// start bit, 8 data bits LSB first, optional even parity, then a stop bit.
//
// Optional feature: define UART_PARITY_EN to add an even-parity bit between
// the data and stop bits (11-bit frame). Without it, frames are 10 bits.
//
// Ports:
//   clk      - system clock; all state updates on the rising edge
//   reset    - synchronous, active-low reset
//   load     - one-cycle strobe: CPU writes din this cycle
//   din      - byte to queue for transmission
//   full     - FIFO holds FIFO_DEPTH entries (registered)
//   busy     - transmitter active or FIFO non-empty (registered)
//   overflow - sticky: a load was dropped because the FIFO was full
//   txd      - serial line, idle high (registered)
module qreg_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       txd
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} txState_t;
`endif

  txState_t        state;
  logic [TW-1:0]   bitTimer;
  logic [2:0]      bitIdx;
  logic [7:0]      shiftReg;
`ifdef UART_PARITY_EN
  logic            parityBit;
`endif

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   fifoCount;

  logic            bitLast;
  logic            stopLast;
  logic            pushEn;
  logic            popEn;
  logic            idleNext;
  logic [CW-1:0]   countNext;
  logic [7:0]      head;

  // Handshake decode: a pop happens from IDLE or on the last STOP cycle.
  always_comb begin
    bitLast   = (bitTimer == TW'(CLKS_PER_BIT - 1));
    stopLast  = (state == STOP) && bitLast;
    pushEn    = load && !full;
    popEn     = (fifoCount != '0) && ((state == IDLE) || stopLast);
    countNext = fifoCount + CW'(pushEn) - CW'(popEn);
    idleNext  = ((state == IDLE) || stopLast) && !popEn;
    head      = fifoMem[rdPtr];
  end

  // FIFO storage; pointers are cleared by reset so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (reset && pushEn) begin
      fifoMem[wrPtr] <= din;
    end
  end

  // FIFO bookkeeping, status flags and transmit FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bitTimer  <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
`ifdef UART_PARITY_EN
      parityBit <= 1'b0;
`endif
      txd       <= 1'b1;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PW'(1);
      if (popEn)  rdPtr <= rdPtr + PW'(1);
      fifoCount <= countNext;
      full      <= (countNext == CW'(FIFO_DEPTH));
      busy      <= !idleNext || (countNext != '0);
      // A full FIFO drops the load even if a pop frees a slot this edge.
      if (load && full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          bitTimer <= '0;
          if (popEn) begin
            shiftReg  <= head;
`ifdef UART_PARITY_EN
            parityBit <= ^head;
`endif
            state     <= START;
            txd       <= 1'b0;
          end else begin
            txd <= 1'b1;
          end
        end

        START: begin
          if (bitLast) begin
            bitTimer <= '0;
            bitIdx   <= '0;
            state    <= DATA;
            txd      <= shiftReg[0];
          end else begin
            bitTimer <= bitTimer + TW'(1);
          end
        end

        DATA: begin
          if (bitLast) begin
            bitTimer <= '0;
            if (bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
              txd   <= parityBit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              txd      <= shiftReg[1];
            end
          end else begin
            bitTimer <= bitTimer + TW'(1);
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (bitLast) begin
            bitTimer <= '0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            bitTimer <= bitTimer + TW'(1);
          end
        end
`endif

        STOP: begin
          if (bitLast) begin
            bitTimer <= '0;
            // Back-to-back: chain straight into the next start bit.
            if (popEn) begin
              shiftReg  <= head;
`ifdef UART_PARITY_EN
              parityBit <= ^head;
`endif
              state     <= START;
              txd       <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            bitTimer <= bitTimer + TW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          bitTimer <= '0;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qreg_uart_tx.sv
// Bench for qreg_uart_tx: stimulus queues expected bytes into a scoreboard;
// a monitor decodes frames on txd and compares them in order.
module tb_qreg_uart_tx;

  localparam int CPB   = 4;
`ifdef UART_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       load, load2;
  logic [7:0] din, din2;
  logic       full, busy, overflow, txd;
  logic       full2, busy2, overflow2, txd2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] expQ [$];
  int startQ [$];

  qreg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din),
    .full(full), .busy(busy), .overflow(overflow), .txd(txd));

  qreg_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .din(din2),
    .full(full2), .busy(busy2), .overflow(overflow2), .txd(txd2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(int budget);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drainTimeout", longint'(n < budget), 1);
  endtask

  // Frame monitor: every bit must hold for CPB cycles; abort on reset.
  initial begin
    logic [10:0] bits;
    logic [8:0]  e;
    bit          aborted, stable;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        startQ.push_back(cyc);
        aborted = 0;
        stable  = 1;
        bits    = '0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (reset !== 1'b1) aborted = 1;
            else if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) stable = 0;
          end
        end
        if (!aborted) begin
          check("bitStable", longint'(stable), 1);
          check("startBit", longint'(bits[0]), 0);
          check("stopBit", longint'(bits[NB-1]), 1);
          check("sbDepth", longint'(expQ.size() != 0), 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("frameData", longint'(bits[8:1]), longint'(e[7:0]));
`ifdef UART_PARITY_EN
            check("parityBit", longint'(bits[9]), longint'(e[8]));
`endif
          end
        end
      end
    end
  end

  initial begin
    int c, s, n0;
    logic [7:0] burst [6];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    reset = 1'b0; load = 1'b0; din = '0; load2 = 1'b0; din2 = '0;

    // Reset state
    tick(3);
    check("rstTxd", longint'(txd), 1);
    check("rstBusy", longint'(busy), 0);
    check("rstFull", longint'(full), 0);
    check("rstOverflow", longint'(overflow), 0);
    reset = 1'b1;
    tick(2);

    // Single byte 0xA5: latency, levels, frame length
    n0 = startQ.size();
    c = cyc;
    load = 1'b1; din = 8'hA5; expQ.push_back({1'b0, 8'hA5});
    tick();
    load = 1'b0;
    check("busyAfterLoad", longint'(busy), 1);
    for (int i = 0; i < 10 && startQ.size() == n0; i++) @(negedge clk);
    check("startSeen", longint'(startQ.size()), longint'(n0 + 1));
    s = (startQ.size() > n0) ? startQ[n0] : c + 2;
    check("latency", longint'(s - c), 2);
    #1;
    while (cyc < s + FRAME - 1) tick();
    check("busyLastCycle", longint'(busy), 1);
    tick();
    check("busyAfterFrame", longint'(busy), 0);
    check("idleTxd", longint'(txd), 1);
    waitIdle(100);

    // Three bytes back to back
    n0 = startQ.size();
    load = 1'b1;
    din = 8'h01; expQ.push_back({1'b1, 8'h01}); tick();
    din = 8'h02; expQ.push_back({1'b1, 8'h02}); tick();
    din = 8'h03; expQ.push_back({1'b0, 8'h03}); tick();
    load = 1'b0;
    waitIdle(300);
    check("b2bFrames", longint'(startQ.size()), longint'(n0 + 3));
    if (startQ.size() >= n0 + 3) begin
      check("b2bGap1", longint'(startQ[n0+1] - startQ[n0]), FRAME);
      check("b2bGap2", longint'(startQ[n0+2] - startQ[n0+1]), FRAME);
    end

    // Six loads while idle: one popped, four queued, sixth dropped
    n0 = startQ.size();
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; din = burst[i];
      if (i < 5) expQ.push_back({^burst[i], burst[i]});
      tick();
      if (i == 4) begin
        check("fullAt4", longint'(full), 1);
        check("noOvfYet", longint'(overflow), 0);
      end
    end
    load = 1'b0;
    check("overflowSet", longint'(overflow), 1);
    check("fullHeld", longint'(full), 1);
    waitIdle(500);
    check("burstFrames", longint'(startQ.size()), longint'(n0 + 5));
    check("overflowSticky", longint'(overflow), 1);
    check("fullCleared", longint'(full), 0);

    // Reset during DATA bit 3 of 0x55; a load during reset is ignored
    c = cyc;
    load = 1'b1; din = 8'h55; expQ.push_back({1'b0, 8'h55});
    tick();
    load = 1'b0;
    s = c + 2;
    while (cyc < s + 17) tick();
    check("midFrameTxd", longint'(txd), 0);
    check("midFrameOvf", longint'(overflow), 1);
    reset = 1'b0; load = 1'b1; din = 8'h99;
    tick();
    reset = 1'b1; load = 1'b0;
    expQ.delete();
    check("abortTxd", longint'(txd), 1);
    check("abortBusy", longint'(busy), 0);
    check("abortFull", longint'(full), 0);
    check("abortOverflow", longint'(overflow), 0);
    n0 = startQ.size();
    tick(60);
    check("noFrameAfterRst", longint'(startQ.size()), longint'(n0));
    check("quietTxd", longint'(txd), 1);
    check("quietBusy", longint'(busy), 0);

    // Parity values for 0x07 (1) and 0x03 (0)
    load = 1'b1;
    din = 8'h07; expQ.push_back({1'b1, 8'h07}); tick();
    din = 8'h03; expQ.push_back({1'b0, 8'h03}); tick();
    load = 1'b0;
    waitIdle(300);

    // CLKS_PER_BIT=2 instance, byte 0xFF
    load2 = 1'b1; din2 = 8'hFF;
    tick();
    load2 = 1'b0;
    check("fastLatencyIdle", longint'(txd2), 1);
    for (int i = 0; i < NB * 2; i++) begin
      int bp;
      logic lvl;
      tick();
      bp  = i / 2;
      lvl = (bp == 0) ? 1'b0 : (bp <= 8) ? 1'b1 : (NB == 11 && bp == 9) ? 1'b0 : 1'b1;
      check($sformatf("fastTxd%0d", i), longint'(txd2), longint'(lvl));
    end
    check("fastBusyLast", longint'(busy2), 1);
    tick();
    check("fastBusyDone", longint'(busy2), 0);
    check("fastOverflow", longint'(overflow2), 0);
    check("fastFull", longint'(full2), 0);
    check("sbEmptyAtEnd", longint'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qreg_uart_tx.md
QREG_UART_TX -- requirements
Module: qreg_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries, power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-005 load  input  1  one-cycle strobe; CPU is writing its output register this cycle.
REQ-006 din  input  8  byte written by CPU; valid when load=1.
REQ-007 full  output  1  registered; FIFO holds FIFO_DEPTH entries.
REQ-008 busy  output  1  registered; FSM not IDLE, or FIFO non-empty.
REQ-009 overflow  output  1  sticky; a load was dropped.
REQ-010 txd  output  1  registered serial line; idle high.

Function
REQ-011 Block SHALL sit downstream of the CPU output register, consuming each byte written there and serialising it as an asynchronous frame on txd.
REQ-012 Push: on an edge with load=1 and full=0, din SHALL be written to the FIFO tail.
REQ-013 Drop: on an edge with load=1 and full=1, din SHALL be discarded and overflow set to 1; this applies even if a pop occurs on the same edge.
REQ-014 Simultaneous push and pop with full=0: both SHALL occur; count unchanged.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order is strict FIFO.
REQ-016 FSM states: IDLE, START, DATA, PARITY (UART_PARITY_EN only), STOP.
REQ-017 IDLE, FIFO non-empty: pop head into shift register, enter START, drive txd=0; else txd=1.
REQ-018 Bit timer SHALL hold each state's txd value for exactly CLKS_PER_BIT cycles.
REQ-019 DATA: 8 bits, LSB first, bit index 0..7; leave after bit 7.
REQ-020 STOP: txd=1 for CLKS_PER_BIT cycles.
REQ-021 Last STOP cycle with FIFO non-empty: pop and enter START directly (back-to-back, no idle cycle); else enter IDLE.
REQ-022 Latency: byte loaded into empty FIFO with FSM in IDLE at edge k SHALL drive txd=0 after edge k+1.
REQ-023 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-024 A byte pushed during a frame SHALL not disturb the frame in progress.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE, empty FIFO, timer 0, txd=1, full=0, busy=0, overflow=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; txd=1 after that edge; queued bytes are lost.
REQ-027 Loads during reset SHALL be ignored.
REQ-028 overflow SHALL clear only by reset.

Configuration
REQ-029 Macro UART_PARITY_EN defined: PARITY state between DATA and STOP, txd = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
REQ-030 UART_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-031 Defaults, no parity, load din=0xA5 once -> txd levels 0,1,0,1,0,0,1,0,1,1, each 4 cycles; 40 cycles total; busy low after.
REQ-032 Load 0x01,0x02,0x03 on consecutive cycles -> three frames back-to-back, 120 cycles, txd never idles high between frames, order preserved.
REQ-033 Load 6 bytes on consecutive cycles while idle -> first popped, next 4 queued, full=1, 6th dropped, overflow=1 sticky; 5 frames sent.
REQ-034 reset=0 for 1 cycle during DATA bit 3 of 0x55 -> txd=1 next cycle, busy=0, FIFO empty, no further frame.
REQ-035 UART_PARITY_EN defined, load 0x07 -> parity bit 1; frame 44 cycles; load 0x03 -> parity bit 0.
REQ-036 CLKS_PER_BIT=2, load 0xFF -> start bit 2 cycles low, then 18 cycles high; frame 20 cycles.
